// File: rtl/jimbo_bus_pkg.sv
// jimbo_bus_pkg: shared memory-bus widths, FSM states and the requester record
package jimbo_bus_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} bus_state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_bus_arbiter_arb2_rr.sv
// arb2_rr: two-input round-robin picker; on a tie the port that did not win last goes first
module arb2_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx = (req0 & req1) ? ~last_owner : req1;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port round-robin arbiter sequencing one memory transaction at a time
module mem_bus_arbiter #(
  parameter int ADDR_W = jimbo_bus_pkg::ADDR_W,
  parameter int DATA_W = jimbo_bus_pkg::DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  import jimbo_bus_pkg::*;
  localparam int CW = 3;
  bus_state_t state_q, state_d;
  mem_req_t req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] ack_q, ack_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic owner_q, owner_d, last_q, last_d, strobe_q, strobe_d, busy_q, busy_d;
  logic grant_valid, grant_idx;

  arb2_rr u_rr (
    .req0(req0),
    .req1(req1),
    .last_owner(last_q),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );

  // every output is a flop: next values for the strobe, ack and busy are decided here
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    cnt_d = cnt_q;
    ack_d = 2'b00;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    owner_d = owner_q;
    last_d = last_q;
    strobe_d = 1'b0;
    if (state_q == IDLE && grant_valid) begin
      state_d = ADDR;
      req_d = grant_idx ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
      owner_d = grant_idx;
      cnt_d = CW'(MEM_LAT - 1);
      strobe_d = grant_idx ? we1 : we0;
    end else if (state_q == ADDR) begin
      if (cnt_q == '0) begin
        state_d = DATA;
        ack_d[owner_q] = 1'b1;
        last_d = owner_q;
        rd0_d = (!req_q.we && !owner_q) ? mem_rdata : rd0_q;
        rd1_d = (!req_q.we && owner_q) ? mem_rdata : rd1_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
        strobe_d = req_q.we;
      end
    end else if (state_q == DATA) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      owner_q <= owner_d;
      last_q <= last_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    mem_addr = req_q.addr;
    mem_wdata = req_q.wdata;
    mem_we = strobe_q;
    mem_oe = strobe_q;
    ack0 = ack_q[0];
    ack1 = ack_q[1];
    rdata0 = rd0_q;
    rdata1 = rd1_q;
    busy = busy_q;
    owner = owner_q;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the shared 4-bit-data / 12-bit-address memory bus between two requesters: port 0 (the CPU core) and port 1 (the program loader / debug port). It sequences one memory transaction at a time through a small FSM, drives the memory address, write data and output-enable lines, and returns read data with a one-cycle acknowledge. It sits between the requesters and the external memory pins.

## Interface
- `ADDR_W`, default 12: memory address width.
- `DATA_W`, default 4: memory data width.
- `MEM_LAT`, default 1: number of ADDR-state cycles before read data is sampled. Legal range 1..8; 0 is illegal.

Ports:
- `clk` in 1: the single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0` in 1: port 0 transaction request; held until `ack0`.
- `we0` in 1: port 0 write (1) or read (0).
- `addr0` in `ADDR_W`: port 0 address.
- `wdata0` in `DATA_W`: port 0 write data.
- `ack0` out 1: port 0 one-cycle completion pulse.
- `rdata0` out `DATA_W`: port 0 read data, valid while `ack0` is high, held afterwards.
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rdata1`: same as port 0, for port 1.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_oe` out 1: data-pin drive enable for the external tri-state (1 = the arbiter drives).
- `mem_rdata` in `DATA_W`: memory read data.
- `busy` out 1: high whenever the state is not IDLE.
- `owner` out 1: port index of the current or last grant.

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE, no request:** if `req0` and `req1` are both low, stay in IDLE.
- **IDLE, one request:** grant the requesting port.
- **IDLE, both requesting:** grant the port that is not `last_owner` (round-robin).
- **On grant:** latch `addr`, `we` and `wdata` from the winning port; set `owner`; load the wait counter with `MEM_LAT`-1; go to ADDR.
- **Latched inputs:** requester inputs are sampled only at grant. Later changes are ignored until the next grant.
- **ADDR:** `mem_addr` shows the latched address. For writes, `mem_we`=1 and `mem_oe`=1 with `mem_wdata` valid. For reads, both are 0.
- **Wait counter:** decrements each ADDR cycle. At the edge where it is 0:
  - capture `mem_rdata` into `rdata[owner]` (reads only; writes leave `rdata` unchanged);
  - set `ack[owner]`;
  - set `last_owner` = `owner`;
  - go to DATA.
- **DATA:** `ack[owner]`=1 for exactly this cycle; `mem_we`=0, `mem_oe`=0; go to IDLE unconditionally.
- **Requester rule:** drop `req` in the cycle after `ack`. A `req` still high in the following IDLE cycle is treated as a new transaction. IDLE always lasts at least one cycle.
- **Non-owner port:** its `req` stays pending untouched. It wins at the next IDLE by round-robin.
- **Reset, asserted at any time:** takes effect immediately and asynchronously:
  - state goes to IDLE;
  - all outputs go to 0, including `ack0/1`, `rdata0/1`, `mem_*`, `busy` and `owner`;
  - `last_owner`=1, so port 0 wins the first tie;
  - any in-flight transaction is aborted with no `ack`.
- **Address wrap:** addresses are used as given; no arithmetic is applied, so 0xFFF is legal.

## Timing
- Cycle 0 is the edge at which IDLE samples `req`.
- `mem_addr` is valid from cycle 1 through cycle `MEM_LAT`.
- `ack` is high in cycle `MEM_LAT`+1.
- Total latency is `MEM_LAT`+1 cycles from request sample to `ack`; throughput is one transaction per `MEM_LAT`+2 cycles.
- All outputs are registered; there are no combinational paths from `req` to any output.
- `mem_rdata` must be stable at the rising edge ending the last ADDR cycle.
- `mem_we`/`mem_oe` never overlap DATA or IDLE, which leaves a turnaround gap of at least 2 cycles between back-to-back writes.

## Structure
- Shared package `jimbo_bus_pkg`:
  - `ADDR_W`=12 and `DATA_W`=4 constants;
  - the `bus_state_t` enum {IDLE, ADDR, DATA};
  - the `mem_req_t` struct {we, addr, wdata}, reusable by the CPU and the loader.
- One sub-module, `arb2_rr`: a combinational two-input round-robin picker. Inputs: `req0`, `req1`, `last_owner`. Outputs: `grant_valid`, `grant_idx`.
- The FSM, wait counter and latches live in `mem_bus_arbiter`.

## Test plan
- Hold `reset` with random inputs -> all outputs 0, `busy`=0. Release `reset` -> still IDLE.
- `MEM_LAT`=1, `req0` read at addr 0x123, `mem_rdata`=0xA -> `mem_addr`=0x123 in cycle 1; `ack0`=1 and `rdata0`=0xA in cycle 2; `mem_we`=`mem_oe`=0 throughout.
- `req1` write at addr 0xFFF with data 0x5 -> `mem_we`=`mem_oe`=1 with `mem_wdata`=0x5 for exactly 1 cycle; `ack1` in cycle 2; `rdata1` unchanged.
- `req0` and `req1` asserted together after reset, each dropped after its `ack` then re-raised together -> grant order 0, 1, 0, 1; `owner` tracks each grant.
- `MEM_LAT`=3, read at addr 0x040 -> `mem_addr` held for cycles 1-3; `ack0` in cycle 4; `mem_rdata` is sampled at the end of cycle 3.
- `reset` asserted mid-ADDR on a port 1 write -> `mem_we` falls immediately with no `ack1`. After release, a tie goes to port 0.
